mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory slave port between up to four valid/ready memory masters: the CPU core, coprocessors and a DMA engine. Each master uses the core's memory protocol: valid/addr/wdata/wstrb held until a one-cycle ready, with `wstrb==0` meaning read. The arbiter sits between the masters and the memory or bus slave. It grants one transaction at a time using round-robin or fixed priority. It also supports lock for atomic read-then-write pairs (xchg) and an optional bus-timeout error.

## Interface
- N_MASTERS, 2: number of masters, legal 2..4; index 0 is highest priority in fixed mode.
- ROUND_ROBIN, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 0: cycles to wait for s_ready before an error completion; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_valid  in  N_MASTERS  per-master request
- m_lock  in  N_MASTERS  keep grant after this transaction completes
- m_addr  in  32*N_MASTERS  packed addresses; master i at [32i+31:32i]
- m_wdata  in  32*N_MASTERS  packed write data
- m_wstrb  in  4*N_MASTERS  packed byte strobes; 0 = read
- m_ready  out  N_MASTERS  one-cycle completion to the granted master only
- m_err  out  N_MASTERS  high with m_ready when the transaction timed out
- m_rdata  out  32  read data, broadcast; valid only while m_ready is high
- s_valid  out  1  slave request, registered
- s_addr, s_wdata  out  32  registered copy of the granted master's request
- s_wstrb  out  4  registered copy of the granted master's strobes
- s_ready  in  1  slave completion; ignored while s_valid is low
- s_rdata  in  32  slave read data
- grant  out  2  index of the current/last granted master (debug)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, LOCKED.
- IDLE:
  - If any m_valid is high, pick a winner `g` and latch its addr/wdata/wstrb into the s_* registers.
  - Set s_valid=1 and go to ACCESS.
- Winner selection:
  - Round-robin: the first requester strictly after `last`, searching cyclically.
  - Fixed priority: the lowest requesting index.
- ACCESS:
  - `m_ready[g] = s_ready & s_valid`, combinational passthrough; `m_rdata = s_rdata`.
  - On s_ready: s_valid<=0 and `last<=g`.
  - Then go to LOCKED if `m_lock[g]` was high in the s_ready cycle, else to IDLE.
- LOCKED:
  - Only master g is eligible. When `m_valid[g]` is high, latch its request and go to ACCESS.
  - If `m_lock[g]` and `m_valid[g]` are both low, return to IDLE.
  - Other masters wait.
- Timeout (TIMEOUT>0):
  - A counter loads TIMEOUT on entry to ACCESS and decrements each ACCESS cycle with s_ready low.
  - When it reaches 0: that cycle asserts `m_ready[g]=1`, `m_err[g]=1`, `m_rdata=32'hDEADBEEF`. Then s_valid<=0 and the FSM follows the same exit as a normal completion.
  - s_ready arriving in the same cycle the counter reaches 0 wins: normal completion, no error.
- Slave rules:
  - The request is frozen in the s_* registers, so a master changing its inputs mid-transaction has no effect.
  - A master dropping m_valid before ready does not abort the transaction; it completes normally.
- Width rules:
  - Counter width is `$clog2(TIMEOUT+1)`; the round-robin pointer is 2 bits.
  - Indices at or above N_MASTERS are never granted.

## Timing
- Reset values: s_valid=0, s_addr/s_wdata=0, s_wstrb=0, m_ready=0, m_err=0, grant=0, busy=0, `last=N_MASTERS-1` (so master 0 wins first), state=IDLE.
- Reset mid-transaction drops s_valid in the next cycle; no m_ready is issued.
- Latency:
  - m_valid high in IDLE at cycle t → s_valid high at t+1.
  - s_ready at cycle k → m_ready[g] at cycle k (combinational).
  - Earliest new grant is at k+1 (IDLE/LOCKED at k+1, s_valid at k+2). This gives one dead cycle between transactions.
- The dead cycle guarantees a master that registers mem_valid<=0 on ready is never re-granted on a stale request.
- Simultaneous requests in IDLE: exactly one grant per selection rule; the losers hold m_valid and are served later.
- Round-robin fairness: each persistently requesting master is served within N_MASTERS transactions.

## Structure
- Shared package (`mem_pkg`): the state encoding, `RDATA_ERR=32'hDEADBEEF`, and the strobe constants `WSTRB_READ=4'b0000` and `WSTRB_DWORD=4'b1111`.
- One natural sub-module: `rr_pick`, a combinational winner selector (inputs req, last, mode; output index plus valid). It is reused by the future coprocessor dispatcher.

## Test plan
- Single master: master 0 reads 0x100 with slave rdata 0xCAFEF00D, ready 2 cycles after s_valid → m_ready[0] for one cycle with m_rdata=0xCAFEF00D; s_valid rises exactly 1 cycle after m_valid.
- Contention, round-robin: masters 0 and 1 request continuously → grants alternate 0,1,0,1 with one idle cycle between them. With ROUND_ROBIN=0 → master 0 is granted every time.
- Lock/xchg: master 1 holds m_lock during a read of 0x40 then writes 0x40 (wstrb 1111) while master 0 requests throughout → both master 1 transactions complete before master 0's first s_valid.
- Timeout: TIMEOUT=8, slave never readies → m_ready[g] and m_err[g] assert 8 cycles after s_valid with m_rdata=0xDEADBEEF; the next request is served normally.
- Timeout race: s_ready asserted in the same cycle the timer expires → m_err stays 0 and m_rdata equals s_rdata.
- Reset mid-access: rst pulsed while s_valid=1 → s_valid=0 the next cycle, no m_ready issued; after reset, master 0 wins first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-arbiter types and constants.
// Imported by the arbiter and its winner selector.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  localparam logic [31:0] RDATA_ERR   = 32'hDEADBEEF;
  localparam logic [3:0]  WSTRB_READ  = 4'b0000;
  localparam logic [3:0]  WSTRB_DWORD = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selector: round-robin after
// `last`, or fixed priority (lowest index) when mode=0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  input  logic         mode,
  output logic [1:0]   idx,
  output logic         found
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = 2'd0;
    found = 1'b0;
    if (mode) begin
      for (int k = N; k >= 1; k--) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && i == (int'(last) + k) % N) begin
            idx   = 2'(i);
            found = 1'b1;
          end
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx   = 2'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates up to four valid/ready masters onto one
// registered slave port with lock and bus timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]   m_valid,
  input  logic [N_MASTERS-1:0]   m_lock,
  input  logic [32*N_MASTERS-1:0] m_addr,
  input  logic [32*N_MASTERS-1:0] m_wdata,
  input  logic [4*N_MASTERS-1:0] m_wstrb,
  output logic [N_MASTERS-1:0]   m_ready,
  output logic [N_MASTERS-1:0]   m_err,
  output logic [31:0]            m_rdata,
  output logic                   s_valid,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_wstrb,
  input  logic                   s_ready,
  input  logic [31:0]            s_rdata,
  output logic [1:0]             grant,
  output logic                   busy
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] LAST_RST =
    2'(N_MASTERS - 1);

  arb_state_t state, state_nx;

  logic [1:0]           g;
  logic [1:0]           last;
  logic [CW-1:0]        cnt;
  logic [1:0]           pick_idx;
  logic                 pick_ok;
  logic [1:0]           load_idx;
  logic [N_MASTERS-1:0] g_oh;
  logic                 sel_valid;
  logic                 sel_lock;
  logic                 load;
  logic                 done;
  logic                 tmo;
  mem_req_t             ld_req;

  rr_pick #(
    .N(N_MASTERS)
  ) u_pick (
    .req   (m_valid),
    .last  (last),
    .mode  (ROUND_ROBIN != 0),
    .idx   (pick_idx),
    .found (pick_ok)
  );

  always_comb begin
    g_oh = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (g == 2'(i)) g_oh[i] = 1'b1;
    end
  end

  assign sel_valid = |(m_valid & g_oh);
  assign sel_lock  = |(m_lock & g_oh);

  // While locked only the holder may be re-latched.
  assign load_idx =
    (state == ST_LOCKED) ? g : pick_idx;

  always_comb begin
    ld_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (load_idx == 2'(i)) begin
        ld_req.addr  = m_addr[32*i +: 32];
        ld_req.wdata = m_wdata[32*i +: 32];
        ld_req.wstrb = m_wstrb[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_ok) begin
          load     = 1'b1;
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        done = s_valid & s_ready;
        // A late s_ready in the expiry cycle still wins.
        tmo  = (TIMEOUT > 0) && s_valid &&
               !s_ready && (cnt == '0);
        if (done || tmo) begin
          state_nx = sel_lock ? ST_LOCKED : ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (sel_valid) begin
          load     = 1'b1;
          state_nx = ST_ACCESS;
        end else if (!sel_lock) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= WSTRB_READ;
      g       <= 2'd0;
      last    <= LAST_RST;
      cnt     <= '0;
    end else if (load) begin
      s_valid <= 1'b1;
      s_addr  <= ld_req.addr;
      s_wdata <= ld_req.wdata;
      s_wstrb <= ld_req.wstrb;
      g       <= load_idx;
      cnt     <= CW'(TIMEOUT);
    end else if (done || tmo) begin
      s_valid <= 1'b0;
      last    <= g;
    end else if (state == ST_ACCESS &&
                 cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign m_ready =
    ((done || tmo) && !rst) ? g_oh : '0;
  assign m_err =
    (tmo && !rst) ? g_oh : '0;
  assign m_rdata = tmo ? RDATA_ERR : s_rdata;
  assign grant   = g;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: grant order,
// completions, lock, timeout, race and reset.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N = 2;

  typedef struct {
    int          m;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
  } gnt_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rd;
    int          age;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    m_valid = '0;
  logic [N-1:0]    m_lock  = '0;
  logic [32*N-1:0] m_addr  = '0;
  logic [32*N-1:0] m_wdata = '0;
  logic [4*N-1:0]  m_wstrb = '0;
  logic [N-1:0]    m_ready, m_err;
  logic [31:0]     m_rdata;
  logic            s_valid;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_wstrb;
  logic            s_ready = 1'b0;
  logic [31:0]     s_rdata = '0;
  logic [1:0]      grant;
  logic            busy;

  logic [N-1:0]    f_m_ready, f_m_err;
  logic [31:0]     f_m_rdata;
  logic            f_s_valid;
  logic [31:0]     f_s_addr, f_s_wdata;
  logic [3:0]      f_s_wstrb;
  logic [1:0]      f_grant;
  logic            f_busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .N_MASTERS(N), .ROUND_ROBIN(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_err(m_err),
    .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  mem_arbiter #(
    .N_MASTERS(N), .ROUND_ROBIN(0), .TIMEOUT(0)
  ) dut_fixed (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_ready(f_m_ready), .m_err(f_m_err),
    .m_rdata(f_m_rdata),
    .s_valid(f_s_valid), .s_addr(f_s_addr),
    .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb),
    .s_ready(f_s_valid), .s_rdata(32'h0),
    .grant(f_grant), .busy(f_busy)
  );

  int ncmp = 0;
  int nfail = 0;
  gnt_t gq[$];
  rsp_t rq[$];
  int slv_delay = 1000;
  int wcnt = 0;
  bit chk_fixed = 0;
  int fixed_seen = 0;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Slave answers slv_delay cycles after s_valid rises.
  always begin
    @(posedge clk);
    #2;
    if (s_valid) begin
      s_ready = (wcnt == slv_delay);
      wcnt++;
    end else begin
      s_ready = 1'b0;
      wcnt = 0;
    end
  end

  logic prev_sv = 1'b0;
  logic prev_rdy = 1'b0;
  int   age = 0;

  always @(negedge clk) begin
    gnt_t ge;
    rsp_t re;
    if (s_valid) age = prev_sv ? age + 1 : 0;
    if (prev_rdy) check("dead_cycle", 32'(s_valid), 0);
    if (s_valid && !prev_sv) begin
      check("gnt_expected", 32'(gq.size() != 0), 1);
      if (gq.size() != 0) begin
        ge = gq.pop_front();
        check("gnt_idx", 32'(grant), 32'(ge.m));
        check("gnt_addr", s_addr, ge.a);
        check("gnt_wdata", s_wdata, ge.wd);
        check("gnt_wstrb", 32'(s_wstrb), 32'(ge.ws));
      end
    end
    if (|m_ready) begin
      check("rsp_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        re = rq.pop_front();
        check("rsp_ready", 32'(m_ready),
              32'(1) << re.m);
        check("rsp_err", 32'(m_err),
              re.err ? (32'(1) << re.m) : 32'(0));
        check("rsp_rdata", m_rdata, re.rd);
        check("rsp_age", 32'(age), 32'(re.age));
      end
    end
    prev_sv  = s_valid;
    prev_rdy = |m_ready;
  end

  logic f_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_fixed && f_s_valid && !f_prev) begin
      check("fixed_gnt", 32'(f_grant), 0);
      fixed_seen++;
    end
    f_prev = f_s_valid;
  end

  task automatic drive(int i, logic v, logic l,
                       logic [31:0] a, logic [31:0] wd,
                       logic [3:0] ws);
    m_valid[i]           = v;
    m_lock[i]            = l;
    m_addr[32*i +: 32]   = a;
    m_wdata[32*i +: 32]  = wd;
    m_wstrb[4*i +: 4]    = ws;
  endtask

  task automatic wait_ready(int i, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_ready[i] !== 1'b1 && n < budget);
    check($sformatf("ready_m%0d", i),
          32'(m_ready[i]), 1);
  endtask

  task automatic xact(int i, logic [31:0] a,
                      logic [31:0] wd, logic [3:0] ws,
                      int ag, logic err,
                      logic [31:0] rd, bit lat);
    gq.push_back('{m: i, a: a, wd: wd, ws: ws});
    rq.push_back('{m: i, err: err, rd: rd, age: ag});
    @(posedge clk);
    #1;
    drive(i, 1'b1, 1'b0, a, wd, ws);
    if (lat) begin
      @(negedge clk);
      check("lat_t0", 32'(s_valid), 0);
      @(negedge clk);
      check("lat_t1", 32'(s_valid), 1);
    end
    wait_ready(i, 40);
    @(posedge clk);
    #1;
    m_valid[i] = 1'b0;
  endtask

  initial begin
    int n;
    int mm;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_valid", 32'(s_valid), 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_s_wstrb", 32'(s_wstrb), 0);
    check("rst_m_ready", 32'(m_ready), 0);
    check("rst_m_err", 32'(m_err), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);

    slv_delay = 2;
    s_rdata = 32'hCAFEF00D;
    xact(0, 32'h100, 32'h0, WSTRB_READ, 2, 1'b0,
         32'hCAFEF00D, 1'b1);

    slv_delay = 0;
    s_rdata = 32'h0BAD0001;
    for (int j = 0; j < 4; j++) begin
      mm = (j % 2 == 0) ? 1 : 0;
      gq.push_back('{m: mm,
        a: (mm == 1) ? 32'h2000 : 32'h1000,
        wd: 32'h0, ws: WSTRB_READ});
      rq.push_back('{m: mm, err: 1'b0,
        rd: 32'h0BAD0001, age: 0});
    end
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h1000, 32'h0, WSTRB_READ);
    drive(1, 1'b1, 1'b0, 32'h2000, 32'h0, WSTRB_READ);
    chk_fixed = 1;
    for (int j = 0; j < 4; j++) begin
      wait_ready((j % 2 == 0) ? 1 : 0, 40);
    end
    @(posedge clk);
    #1;
    m_valid = '0;
    chk_fixed = 0;
    check("fixed_seen", 32'(fixed_seen >= 2), 1);
    repeat (2) @(negedge clk);
    check("rr_drained", 32'(rq.size()), 0);

    slv_delay = 1;
    s_rdata = 32'h11112222;
    gq.push_back('{m: 1, a: 32'h40, wd: 32'h0,
                   ws: WSTRB_READ});
    gq.push_back('{m: 1, a: 32'h40, wd: 32'h55AA55AA,
                   ws: WSTRB_DWORD});
    gq.push_back('{m: 0, a: 32'h200, wd: 32'h0,
                   ws: WSTRB_READ});
    rq.push_back('{m: 1, err: 1'b0,
                   rd: 32'h11112222, age: 1});
    rq.push_back('{m: 1, err: 1'b0,
                   rd: 32'h11112222, age: 1});
    rq.push_back('{m: 0, err: 1'b0,
                   rd: 32'h11112222, age: 1});
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 32'h40, 32'h0, WSTRB_READ);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h200, 32'h0, WSTRB_READ);
    wait_ready(1, 40);
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b0, 32'h40, 32'h55AA55AA,
          WSTRB_DWORD);
    wait_ready(1, 40);
    @(posedge clk);
    #1;
    m_valid[1] = 1'b0;
    wait_ready(0, 40);
    @(posedge clk);
    #1;
    m_valid[0] = 1'b0;

    slv_delay = 1000;
    s_rdata = 32'h77770000;
    xact(0, 32'h300, 32'h0, WSTRB_READ, 8, 1'b1,
         RDATA_ERR, 1'b0);
    slv_delay = 1;
    xact(1, 32'h304, 32'hA5A50001, WSTRB_DWORD, 1,
         1'b0, 32'h77770000, 1'b0);

    slv_delay = 8;
    s_rdata = 32'h12345678;
    xact(0, 32'h308, 32'h0, WSTRB_READ, 8, 1'b0,
         32'h12345678, 1'b0);

    slv_delay = 1000;
    gq.push_back('{m: 1, a: 32'h500, wd: 32'h0,
                   ws: WSTRB_READ});
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b0, 32'h500, 32'h0, WSTRB_READ);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_valid !== 1'b1 && n < 20);
    check("rst_sv_up", 32'(s_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_valid = '0;
    @(negedge clk);
    check("rst_no_ready", 32'(m_ready), 0);
    @(negedge clk);
    check("rst_sv_drop", 32'(s_valid), 0);
    check("rst_no_ready2", 32'(m_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_grant", 32'(grant), 0);
    check("rst2_busy", 32'(busy), 0);

    slv_delay = 1;
    s_rdata = 32'h600D0000;
    gq.push_back('{m: 0, a: 32'h600, wd: 32'h0,
                   ws: WSTRB_READ});
    gq.push_back('{m: 1, a: 32'h700, wd: 32'h0,
                   ws: WSTRB_READ});
    rq.push_back('{m: 0, err: 1'b0,
                   rd: 32'h600D0000, age: 1});
    rq.push_back('{m: 1, err: 1'b0,
                   rd: 32'h600D0000, age: 1});
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h600, 32'h0, WSTRB_READ);
    drive(1, 1'b1, 1'b0, 32'h700, 32'h0, WSTRB_READ);
    wait_ready(0, 40);
    @(posedge clk);
    #1;
    m_valid[0] = 1'b0;
    wait_ready(1, 40);
    @(posedge clk);
    #1;
    m_valid[1] = 1'b0;

    repeat (3) @(negedge clk);
    check("final_gq_empty", 32'(gq.size()), 0);
    check("final_rq_empty", 32'(rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
